// File: rtl/ads_frame_scheduler.sv
// ads_frame_scheduler: sequences every SPI frame sent to the ADS8685.
// After reset it waits INIT_DELAY cycles and runs the register configuration.
// It then shares the single 32-bit frame engine between the periodic sample
// readout and the host register port. Sample readout has priority; a host
// read is a command frame followed by a NOP frame, and the two are never split.
module ads_frame_scheduler #(
    parameter int SAMPLE_DIV = 200,
    parameter int INIT_DELAY = 1000,
    parameter int TIMEOUT    = 255
) (
    input  logic        clk_ref,
    input  logic        sys_rstn,
    input  logic        run_en,
    input  logic        host_req,
    input  logic        host_wr,
    input  logic [7:0]  host_addr,
    input  logic [15:0] host_wdata,
    output logic        host_ack,
    output logic [15:0] host_rdata,
    output logic        frm_start,
    output logic [31:0] frm_cmd,
    input  logic        frm_busy,
    input  logic        frm_done,
    input  logic [31:0] frm_rdata,
    output logic        smp_valid,
    output logic [15:0] smp_data,
    output logic        smp_overrun,
    output logic        init_done,
    output logic        timeout_err
);
    localparam int PW = $clog2(INIT_DELAY + 1);
    localparam int DW = $clog2(SAMPLE_DIV);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {PWR, INIT, IDLE, ISSUE, WAIT, DONE} state_t;
    // What the frame currently in flight belongs to
    typedef enum logic [2:0] {K_INIT, K_SMP, K_HWR, K_HRD1, K_HRD2} kind_t;

    state_t        state;
    kind_t         kind;
    logic [PW-1:0] pwr_cnt;
    logic [DW-1:0] tick_cnt;
    logic [TW-1:0] to_cnt;
    logic [1:0]    init_idx;
    logic [31:0]   cmd_q;
    logic          sample_pending;

    logic          tick;
    logic          tick_run;
    logic          smp_fin;
    logic [7:0]    req_addr;
    logic          unused_bits;

    // Power-up configuration: three register writes then a flushing NOP
    function automatic logic [31:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    init_cmd = {8'hD0, 8'h0C, 16'h0000};
            2'd1:    init_cmd = {8'hD0, 8'h10, 16'h0000};
            2'd2:    init_cmd = {8'hD0, 8'h14, 16'h0001};
            default: init_cmd = 32'h0000_0000;
        endcase
    endfunction

    assign tick     = init_done && (tick_cnt == DW'(SAMPLE_DIV - 1));
    assign tick_run = tick && run_en;
    // A sample frame leaves WAIT this cycle, either completed or timed out
    assign smp_fin  = (state == WAIT) && (kind == K_SMP) &&
                      (frm_done || (to_cnt == TW'(TIMEOUT)));
    assign req_addr = {host_addr[7:1], 1'b0};
    // Low half of the returned word and address bit 0 carry nothing we use
    assign unused_bits = ^{frm_rdata[15:0], host_addr[0]};

    // Free-running sample tick divider, started by init_done
    always_ff @(posedge clk_ref or negedge sys_rstn) begin
        if (!sys_rstn) begin
            tick_cnt <= '0;
        end else if (!init_done || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + DW'(1);
        end
    end

    // Pending-sample flag; a tick on an unserved sample reports an overrun.
    // A sample finishing in the same cycle as a tick does not count as unserved.
    always_ff @(posedge clk_ref or negedge sys_rstn) begin
        if (!sys_rstn) begin
            sample_pending <= 1'b0;
            smp_overrun    <= 1'b0;
        end else begin
            smp_overrun <= tick_run && sample_pending && !smp_fin;
            if (tick_run) begin
                sample_pending <= 1'b1;
            end else if (smp_fin) begin
                sample_pending <= 1'b0;
            end
        end
    end

    // Frame sequencer with registered outputs
    always_ff @(posedge clk_ref or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state       <= PWR;
            kind        <= K_INIT;
            pwr_cnt     <= '0;
            to_cnt      <= '0;
            init_idx    <= '0;
            cmd_q       <= '0;
            frm_start   <= 1'b0;
            frm_cmd     <= '0;
            host_ack    <= 1'b0;
            host_rdata  <= '0;
            smp_valid   <= 1'b0;
            smp_data    <= '0;
            init_done   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            frm_start <= 1'b0;
            host_ack  <= 1'b0;
            smp_valid <= 1'b0;
            case (state)
                PWR: begin
                    if (pwr_cnt == PW'(INIT_DELAY - 1)) begin
                        state <= INIT;
                    end else begin
                        pwr_cnt <= pwr_cnt + PW'(1);
                    end
                end
                INIT: begin
                    cmd_q <= init_cmd(init_idx);
                    kind  <= K_INIT;
                    state <= ISSUE;
                end
                IDLE: begin
                    // The live tick is looked at directly so a sample launches
                    // without waiting for the pending flag to register
                    if (sample_pending || tick_run) begin
                        cmd_q <= 32'h0000_0000;
                        kind  <= K_SMP;
                        state <= ISSUE;
                    end else if (host_req) begin
                        kind  <= host_wr ? K_HWR : K_HRD1;
                        cmd_q <= host_wr ? {8'hD0, req_addr, host_wdata}
                                         : {8'hC8, req_addr, 16'h0000};
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!frm_busy) begin
                        frm_start <= 1'b1;
                        frm_cmd   <= cmd_q;
                        to_cnt    <= '0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (frm_done) begin
                        state <= DONE;
                        case (kind)
                            K_INIT: begin
                                if (init_idx == 2'd3) begin
                                    init_done <= 1'b1;
                                end
                                init_idx <= init_idx + 2'd1;
                            end
                            K_SMP: begin
                                smp_valid <= 1'b1;
                                smp_data  <= frm_rdata[31:16];
                            end
                            K_HWR: host_ack <= 1'b1;
                            K_HRD2: begin
                                host_ack   <= 1'b1;
                                host_rdata <= frm_rdata[31:16];
                            end
                            default: ;
                        endcase
                    end else if (to_cnt == TW'(TIMEOUT)) begin
                        timeout_err <= 1'b1;
                        if (kind == K_INIT) begin
                            init_idx <= '0;
                            state    <= INIT;
                        end else begin
                            state <= IDLE;
                            if (kind != K_SMP) begin
                                host_ack   <= 1'b1;
                                host_rdata <= 16'hFFFF;
                            end
                        end
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                DONE: begin
                    case (kind)
                        K_INIT: state <= init_done ? IDLE : INIT;
                        // Second half of a host read goes out before anything else
                        K_HRD1: begin
                            cmd_q <= 32'h0000_0000;
                            kind  <= K_HRD2;
                            state <= ISSUE;
                        end
                        default: state <= IDLE;
                    endcase
                end
                default: state <= PWR;
            endcase
        end
    end
endmodule

// File: tb/tb_ads_frame_scheduler.sv
// Bench for ads_frame_scheduler: a behavioural frame-engine / ADS register
// model, a table of host transactions, and hand sequences for sampling,
// overrun, timeouts and mid-frame reset.
module tb_ads_frame_scheduler;
    localparam int ENG_LAT = 66;

    logic        clk_ref = 1'b0;
    logic        sys_rstn;
    logic        run_en;
    logic        host_req;
    logic        host_wr;
    logic [7:0]  host_addr;
    logic [15:0] host_wdata;
    logic        host_ack;
    logic [15:0] host_rdata;
    logic        frm_start;
    logic [31:0] frm_cmd;
    logic        frm_busy  = 1'b0;
    logic        frm_done  = 1'b0;
    logic [31:0] frm_rdata = 32'h0;
    logic        smp_valid;
    logic [15:0] smp_data;
    logic        smp_overrun;
    logic        init_done;
    logic        timeout_err;

    ads_frame_scheduler dut (
        .clk_ref(clk_ref), .sys_rstn(sys_rstn), .run_en(run_en),
        .host_req(host_req), .host_wr(host_wr), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
        .frm_start(frm_start), .frm_cmd(frm_cmd), .frm_busy(frm_busy),
        .frm_done(frm_done), .frm_rdata(frm_rdata), .smp_valid(smp_valid),
        .smp_data(smp_data), .smp_overrun(smp_overrun), .init_done(init_done),
        .timeout_err(timeout_err)
    );

    always #5 clk_ref = ~clk_ref;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clk_ref) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Engine / device model state
    logic        stall = 1'b0;
    int          eng_cnt = 0;
    logic [31:0] eng_cmd = 32'h0;
    logic [15:0] regs [256];
    logic        pend_rd = 1'b0;
    logic [7:0]  pend_addr = 8'h0;
    logic [31:0] cmd_log [$];
    int          start_cyc [$];
    int          smp_cnt = 0;
    int          ovr_cnt = 0;
    int          last_smp = 0;
    logic        chk_iv = 1'b0;
    logic        init_q = 1'b0;

    // Monitor first (frm_done still shows what the DUT sampled at the last
    // rising edge), then advance the engine model
    always @(negedge clk_ref) begin
        if (smp_valid) begin
            smp_cnt++;
            check("smp_data", 32'(smp_data), 32'h1234);
            check("smp_lat", 32'(frm_done), 32'd1);
            if (chk_iv && last_smp != 0) check("smp_period", cyc - last_smp, 32'd200);
            last_smp = cyc;
        end
        if (smp_overrun) ovr_cnt++;
        if (init_done && !init_q) check("init_lat", 32'(frm_done), 32'd1);
        init_q = init_done;

        frm_done = 1'b0;
        if (!sys_rstn) begin
            frm_busy = 1'b0;
            eng_cnt  = 0;
            pend_rd  = 1'b0;
        end else if (frm_start) begin
            check("start_idle", 32'(frm_busy), 32'd0);
            frm_busy = 1'b1;
            eng_cnt  = ENG_LAT;
            eng_cmd  = frm_cmd;
            cmd_log.push_back(frm_cmd);
            start_cyc.push_back(cyc);
        end else if (frm_busy) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
                frm_busy = 1'b0;
                if (!stall) begin
                    frm_done = 1'b1;
                    if (eng_cmd[31:24] == 8'hD0) begin
                        regs[eng_cmd[23:16]] = eng_cmd[15:0];
                        frm_rdata = 32'h0;
                    end else if (eng_cmd[31:24] == 8'hC8) begin
                        pend_rd   = 1'b1;
                        pend_addr = eng_cmd[23:16];
                        frm_rdata = 32'h0;
                    end else begin
                        frm_rdata = pend_rd ? {regs[pend_addr], 16'h0000} : 32'h1234_A5A5;
                        pend_rd   = 1'b0;
                    end
                end
            end
        end
    end

    task automatic host_txn(input logic wr, input logic [7:0] addr, input logic [15:0] wd,
                            output logic [15:0] rd, output logic got, output logic with_done);
        host_wr = wr; host_addr = addr; host_wdata = wd; host_req = 1'b1;
        got = 1'b0; rd = 16'h0; with_done = 1'b0;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(posedge clk_ref); #1;
            if (host_ack) begin
                got = 1'b1; rd = host_rdata; with_done = frm_done;
            end
        end
        host_req = 1'b0;
    endtask

    task automatic wait_init(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(posedge clk_ref); #1;
            if (init_done) ok = 1'b1;
        end
    endtask

    task automatic wait_smp(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(posedge clk_ref); #1;
            if (smp_valid) ok = 1'b1;
        end
    endtask

    task automatic check_init(input string tag, input int rel);
        logic ok;
        logic [31:0] exp [4];
        exp = '{32'hD00C_0000, 32'hD010_0000, 32'hD014_0001, 32'h0000_0000};
        wait_init(ok);
        check({tag, "_init_done"}, 32'(ok), 32'd1);
        check({tag, "_nfrm"}, cmd_log.size(), 32'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("%s_frm%0d", tag, i),
                  (i < cmd_log.size()) ? cmd_log[i] : 32'hDEAD_DEAD, exp[i]);
        check({tag, "_pwr_delay"}, 32'(start_cyc.size() > 0 && start_cyc[0] - rel >= 1000 &&
                                       start_cyc[0] - rel <= 1005), 32'd1);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_frm_cmd"}, frm_cmd, 32'h0);
        check({tag, "_host_rdata"}, 32'(host_rdata), 32'h0);
        check({tag, "_smp_data"}, 32'(smp_data), 32'h0);
        check({tag, "_flags"}, 32'({host_ack, frm_start, smp_valid, smp_overrun,
                                    init_done, timeout_err}), 32'h0);
    endtask

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [31:0] cmd0;
        logic [31:0] cmd1;
        logic [15:0] rdata;
    } vec_t;

    initial begin
        vec_t        vt [6];
        logic [15:0] rd;
        logic        got, wd, ok;
        int          rel, ack_cyc, to_cyc;

        vt[0] = '{1'b1, 8'h10, 16'h00AB, 32'hD010_00AB, 32'h0, 16'h0000};
        vt[1] = '{1'b0, 8'h10, 16'h0000, 32'hC810_0000, 32'h0, 16'h00AB};
        vt[2] = '{1'b1, 8'h21, 16'h5A5A, 32'hD020_5A5A, 32'h0, 16'h00AB};
        vt[3] = '{1'b0, 8'h21, 16'h0000, 32'hC820_0000, 32'h0, 16'h5A5A};
        vt[4] = '{1'b0, 8'h0C, 16'h0000, 32'hC80C_0000, 32'h0, 16'h0000};
        vt[5] = '{1'b0, 8'h15, 16'h0000, 32'hC814_0000, 32'h0, 16'h0001};

        for (int i = 0; i < 256; i++) regs[i] = 16'h0;
        sys_rstn = 1'b0; run_en = 1'b0; host_req = 1'b0; host_wr = 1'b0;
        host_addr = 8'h0; host_wdata = 16'h0;

        // Reset state and power-up configuration
        repeat (3) @(posedge clk_ref); #1;
        check_reset_outs("rst");
        @(negedge clk_ref); sys_rstn = 1'b1; rel = cyc;
        check_init("pwrup", rel);

        // Host transaction table, sampling off
        for (int i = 0; i < 6; i++) begin
            repeat (2) @(posedge clk_ref); #1;
            cmd_log.delete(); start_cyc.delete();
            host_txn(vt[i].wr, vt[i].addr, vt[i].wdata, rd, got, wd);
            check($sformatf("v%0d_ack", i), 32'(got), 32'd1);
            check($sformatf("v%0d_ack_lat", i), 32'(wd), 32'd1);
            check($sformatf("v%0d_rdata", i), 32'(rd), 32'(vt[i].rdata));
            check($sformatf("v%0d_nfrm", i), cmd_log.size(), vt[i].wr ? 32'd1 : 32'd2);
            check($sformatf("v%0d_cmd0", i), (cmd_log.size() > 0) ? cmd_log[0] : 32'hDEAD_DEAD, vt[i].cmd0);
            if (!vt[i].wr) begin
                check($sformatf("v%0d_cmd1", i), (cmd_log.size() > 1) ? cmd_log[1] : 32'hDEAD_DEAD, vt[i].cmd1);
                check($sformatf("v%0d_b2b", i),
                      (start_cyc.size() > 1) ? start_cyc[1] - start_cyc[0] : 0, 32'd69);
            end
        end
        check("no_smp_when_off", smp_cnt, 32'd0);

        // Periodic sampling, exact 200-cycle spacing
        run_en = 1'b1; chk_iv = 1'b1; last_smp = 0; ovr_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            wait_smp(ok);
            check($sformatf("smp%0d_seen", i), 32'(ok), 32'd1);
        end
        chk_iv = 1'b0;

        // Host write arriving together with a tick: sample NOP goes first
        wait_smp(ok);
        repeat (131) @(posedge clk_ref); #1;
        cmd_log.delete(); start_cyc.delete();
        host_txn(1'b1, 8'h10, 16'h00AB, rd, got, wd);
        check("wr_smp_ack", 32'({got, wd}), 32'd3);
        check("wr_smp_first", (cmd_log.size() > 0) ? cmd_log[0] : 32'hDEAD_DEAD, 32'h0);
        check("wr_smp_second", (cmd_log.size() > 1) ? cmd_log[1] : 32'hDEAD_DEAD, 32'hD010_00AB);

        // Host read with a tick landing between its two frames
        wait_smp(ok);
        repeat (10) @(posedge clk_ref); #1;
        cmd_log.delete(); start_cyc.delete();
        host_txn(1'b0, 8'h10, 16'h0, rd, got, wd);
        ack_cyc = cyc;
        repeat (6) @(posedge clk_ref); #1;
        check("rd_smp_ack", 32'({got, wd}), 32'd3);
        check("rd_smp_rdata", 32'(rd), 32'h00AB);
        check("rd_smp_nfrm", cmd_log.size(), 32'd3);
        check("rd_smp_cmd0", (cmd_log.size() > 0) ? cmd_log[0] : 32'hDEAD_DEAD, 32'hC810_0000);
        check("rd_smp_cmd1", (cmd_log.size() > 1) ? cmd_log[1] : 32'hDEAD_DEAD, 32'h0);
        check("rd_smp_cmd2", (cmd_log.size() > 2) ? cmd_log[2] : 32'hDEAD_DEAD, 32'h0);
        check("rd_smp_b2b", (start_cyc.size() > 1) ? start_cyc[1] - start_cyc[0] : 0, 32'd69);
        check("rd_smp_nop_lat", (start_cyc.size() > 2) ? start_cyc[2] - ack_cyc : 0, 32'd3);
        check("no_overrun", ovr_cnt, 32'd0);

        // Engine stops answering a sample frame: one overrun, then timeout
        wait_smp(ok);
        stall = 1'b1; ovr_cnt = 0;
        cmd_log.delete(); start_cyc.delete();
        to_cyc = 0;
        for (int i = 0; i < 600 && to_cyc == 0; i++) begin
            @(posedge clk_ref); #1;
            if (timeout_err) to_cyc = cyc;
        end
        stall = 1'b0;
        check("to_seen", 32'(to_cyc != 0), 32'd1);
        check("to_one_start", start_cyc.size(), 32'd1);
        check("to_delay", (start_cyc.size() > 0) ? to_cyc - start_cyc[0] : 0, 32'd256);
        wait_smp(ok);
        check("to_smp_resume", 32'(ok), 32'd1);
        check("overrun_once", ovr_cnt, 32'd1);
        host_txn(1'b1, 8'h14, 16'h0001, rd, got, wd);
        check("to_next_host", 32'({got, wd}), 32'd3);

        // Host read timing out is acked with all-ones
        run_en = 1'b0;
        repeat (300) @(posedge clk_ref); #1;
        stall = 1'b1;
        host_txn(1'b0, 8'h10, 16'h0, rd, got, wd);
        stall = 1'b0;
        check("hto_ack", 32'(got), 32'd1);
        check("hto_no_done", 32'(wd), 32'd0);
        check("hto_rdata", 32'(rd), 32'hFFFF);
        check("hto_sticky", 32'(timeout_err), 32'd1);
        repeat (2) @(posedge clk_ref); #1;
        host_txn(1'b0, 8'h10, 16'h0, rd, got, wd);
        check("hto_after_rdata", 32'({got, wd, rd}), {14'h0, 2'b11, 16'h00AB});

        // Reset in the middle of a frame
        run_en = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(posedge clk_ref); #1;
            if (frm_start) ok = 1'b1;
        end
        check("mid_start_seen", 32'(ok), 32'd1);
        repeat (10) @(posedge clk_ref);
        #2 sys_rstn = 1'b0;
        #1 check_reset_outs("midrst");
        repeat (3) @(negedge clk_ref);
        cmd_log.delete(); start_cyc.delete();
        sys_rstn = 1'b1; rel = cyc;
        check_init("rerun", rel);
        check("rerun_to_clear", 32'(timeout_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
